// File: rtl/and2_resp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : and2_resp_monitor
// Brief    : Response-side monitor for the and2 interface. Checks y == a & b,
//            counts passes/errors and buffers checked transactions in a FIFO.
// Option   : AND2_MON_STOP_ON_ERR_EN - halt capture on first mismatch until clr
// Revision : 1.0 - initial release
// ============================================================================
module and2_resp_monitor #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_y,
   output logic             out_err,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fifo_full,
   output logic             halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int EW = 3 * WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           state_q;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [OW-1:0]    occ_q;
   logic [OW-1:0]    occ_d;
   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] err_q;

   logic             w_full;
   logic             w_accept;
   logic             w_pop;
   logic             w_mismatch;
   logic [EW-1:0]    w_head;

   assign w_full     = (occ_q == OW'(DEPTH));
   assign in_ready   = (state_q == S_RUN) && !w_full && !clr;
   assign w_accept   = in_valid && in_ready;
   assign w_mismatch = (in_y != (in_a & in_b));
   assign out_valid  = (occ_q != '0);
   assign w_pop      = out_valid && out_ready;

   // -------------------------------------------------------------------------
   // Control FSM; clr overrides every other event.
   // -------------------------------------------------------------------------
`ifdef AND2_MON_STOP_ON_ERR_EN
   logic halted_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         halted_q <= 1'b0;
      end else if (clr) begin
         state_q  <= S_IDLE;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (en) state_q <= S_RUN;
            S_RUN: begin
               if (w_accept && w_mismatch) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else if (!en) begin
                  state_q <= S_IDLE;
               end
            end
            S_HALT: state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign halted = halted_q;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else if (clr) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (en) state_q <= S_RUN;
            S_RUN:   if (!en) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign halted = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FIFO storage, pointers and counters
   // -------------------------------------------------------------------------
   always_comb begin
      occ_d = occ_q;
      if (w_accept && !w_pop)
         occ_d = occ_q + OW'(1);
      else if (!w_accept && w_pop)
         occ_d = occ_q - OW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (w_accept) begin
         mem_q[wr_ptr_q] <= {in_a, in_b, in_y, w_mismatch};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         pass_q   <= '0;
         err_q    <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         pass_q   <= '0;
         err_q    <= '0;
      end else begin
         occ_q <= occ_d;
         if (w_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (w_accept) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            // Counters stick at all-ones rather than wrapping.
            if (w_mismatch) begin
               if (err_q != '1) err_q <= err_q + CNT_W'(1);
            end else begin
               if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
            end
         end
      end
   end

   assign w_head    = mem_q[rd_ptr_q];
   assign out_a     = w_head[EW-1 -: WIDTH];
   assign out_b     = w_head[EW-1-WIDTH -: WIDTH];
   assign out_y     = w_head[WIDTH:1];
   assign out_err   = w_head[0];
   assign pass_cnt  = pass_q;
   assign err_cnt   = err_q;
   assign fifo_full = w_full;

endmodule
`default_nettype wire

// File: tb/tb_and2_resp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_and2_resp_monitor
// Brief    : Scoreboard bench for and2_resp_monitor (narrow counters so that
//            saturation is reachable). Honours AND2_MON_STOP_ON_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_and2_resp_monitor;

   localparam int WIDTH = 1;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CMAX = '1;
`ifdef AND2_MON_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n, en, clr, in_valid, out_ready;
   logic [WIDTH-1:0] in_a, in_b, in_y;
   logic             in_ready, out_valid, out_err, fifo_full, halted;
   logic [WIDTH-1:0] out_a, out_b, out_y;
   logic [CNT_W-1:0] pass_cnt, err_cnt;

   always #5 clk = ~clk;

   and2_resp_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_y(out_y), .out_err(out_err),
      .pass_cnt(pass_cnt), .err_cnt(err_cnt),
      .fifo_full(fifo_full), .halted(halted)
   );

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] y;
      logic             e;
   } ent_t;

   ent_t             sb[$];
   int               n_chk = 0;
   int               n_err = 0;
   logic             m_run, m_halt;
   logic [CNT_W-1:0] m_pass, m_errc;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_run  = 1'b0;
      m_halt = 1'b0;
      m_pass = '0;
      m_errc = '0;
   endtask

   // One clock: compare at negedge, advance model, then return 1 after posedge.
   task automatic step();
      bit   m_full, m_rdy, acc, pop, e;
      ent_t h;
      @(negedge clk);
      if (!rst_n) model_reset();
      m_full = (sb.size() == DEPTH);
      m_rdy  = m_run && !m_full && !clr;
      check("in_ready",  32'(in_ready),  32'(m_rdy));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("fifo_full", 32'(fifo_full), 32'(m_full));
      check("pass_cnt",  32'(pass_cnt),  32'(m_pass));
      check("err_cnt",   32'(err_cnt),   32'(m_errc));
      check("halted",    32'(halted),    32'(m_halt));
      if (sb.size() != 0) begin
         h = sb[0];
         check("out_a",   32'(out_a),   32'(h.a));
         check("out_b",   32'(out_b),   32'(h.b));
         check("out_y",   32'(out_y),   32'(h.y));
         check("out_err", 32'(out_err), 32'(h.e));
      end
      if (rst_n) begin
         acc = in_valid && m_rdy;
         pop = (sb.size() != 0) && out_ready;
         e   = (in_y != (in_a & in_b));
         if (clr) begin
            model_reset();
         end else begin
            if (pop) void'(sb.pop_front());
            if (acc) begin
               sb.push_back('{a: in_a, b: in_b, y: in_y, e: e});
               if (e) begin
                  if (m_errc != CMAX) m_errc = m_errc + 1'b1;
               end else begin
                  if (m_pass != CMAX) m_pass = m_pass + 1'b1;
               end
            end
            if (m_run) begin
               if (acc && e && STOP) begin
                  m_run  = 1'b0;
                  m_halt = 1'b1;
               end else if (!en) begin
                  m_run = 1'b0;
               end
            end else if (!m_halt && en) begin
               m_run = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] y);
      in_valid = v;
      in_a     = v ? a : 'x;
      in_b     = v ? b : 'x;
      in_y     = v ? y : 'x;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0, '0, '0);
      model_reset();
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_pass_cnt",  32'(pass_cnt),  32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // First good transaction and latency
      en = 1'b1;
      step();
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      step();
      drive(1'b0, '0, '0, '0);
      step();
      out_ready = 1'b1;
      step();

      // Mismatch
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, '0, '0);
      step();
      check("after_err_in_ready", 32'(in_ready), 32'(!STOP));
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      step();

      // Fill to full, then pop with in_valid held
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'(i), 1'(i >> 1), 1'(i) & 1'(i >> 1));
         step();
      end
      check("full_flag", 32'(fifo_full), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();

      // Saturate the pass counter
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, '0);
      step();
      check("pass_sat", 32'(pass_cnt), 32'(CMAX));

      // Three transactions then clr; capture resumes afterwards
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b1);
         step();
      end
      drive(1'b0, '0, '0, '0);
      clr = 1'b1; en = 1'b0;
      step();
      clr = 1'b0;
      step();
      check("clr_out_valid", 32'(out_valid), 32'd0);
      en = 1'b1;
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      step();
      step();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         logic a, b;
         a = 1'($urandom);
         b = 1'($urandom);
         drive(1'($urandom_range(0, 2) != 0), a, b, (a & b) ^ 1'($urandom_range(0, 9) == 0));
         out_ready = 1'($urandom_range(0, 2) != 0);
         en        = ($urandom_range(0, 19) != 0);
         clr       = ($urandom_range(0, 29) == 0);
         step();
      end
      clr = 1'b0; en = 1'b1; out_ready = 1'b0;
      drive(1'b0, '0, '0, '0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      step();

      // Async reset in the middle of an accepting cycle
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready",  32'(in_ready),  32'd0);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_pass_cnt",  32'(pass_cnt),  32'd0);
      check("arst_fifo_full", 32'(fifo_full), 32'd0);
      model_reset();
      step();
      rst_n = 1'b1;
      drive(1'b0, '0, '0, '0);
      step();
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
